// File: rtl/mdu_ctrl.sv
// Multiply/divide unit sequencer for the EX stage: single-cycle magnitude
// multiply and a 32-step restoring divider, with flush and HI/LO writeback.
module mdu_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        annul,
    output logic        stall_out,
    output logic        busy,
    output logic        done,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {IDLE, MUL, DIV_RUN, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] rem;
    logic        sgn;
    logic        sa;
    logic        sb;

    logic        in_sgn;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [32:0] shl;
    logic [32:0] diff;
    logic        fit;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // op[0]=0 selects the signed flavours (MULT, DIV)
    assign in_sgn = ~op[0];
    assign abs1   = (in_sgn && src1[31]) ? -src1 : src1;
    assign abs2   = (in_sgn && src2[31]) ? -src2 : src2;

    assign neg_q    = sgn & (sa ^ sb);
    assign neg_r    = sgn & sa;
    assign prod     = {32'd0, opa} * {32'd0, opb};
    assign prod_fix = neg_q ? -prod : prod;

    // Dividend shifts out of opa MSB-first while quotient bits shift in
    assign shl     = {rem, opa[31]};
    assign diff    = shl - {1'b0, opb};
    assign fit     = ~diff[32];
    assign rem_nx  = fit ? diff[31:0] : shl[31:0];
    assign quo_nx  = {opa[30:0], fit};
    assign quo_fix = neg_q ? -quo_nx : quo_nx;
    assign rem_fix = neg_r ? -rem_nx : rem_nx;

    assign busy      = (state != IDLE);
    assign stall_out = ((state == IDLE) && start && !annul)
                     || (state == MUL) || (state == DIV_RUN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            opa     <= 32'd0;
            opb     <= 32'd0;
            rem     <= 32'd0;
            sgn     <= 1'b0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            done    <= 1'b0;
            hilo_we <= 1'b0;
            hi_out  <= 32'd0;
            lo_out  <= 32'd0;
        end else begin
            done    <= 1'b0;
            hilo_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !annul) begin
                        sgn <= in_sgn;
                        sa  <= in_sgn & src1[31];
                        sb  <= in_sgn & src2[31];
                        opa <= abs1;
                        opb <= abs2;
                        rem <= 32'd0;
                        cnt <= 5'd0;
                        if (!op[1]) begin
                            state <= MUL;
                        end else if (src2 == 32'd0) begin
                            state   <= DONE;
                            hi_out  <= 32'd0;
                            lo_out  <= 32'd0;
                            done    <= 1'b1;
                            hilo_we <= 1'b1;
                        end else begin
                            state <= DIV_RUN;
                        end
                    end
                end
                MUL: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        hi_out  <= prod_fix[63:32];
                        lo_out  <= prod_fix[31:0];
                        done    <= 1'b1;
                        hilo_we <= 1'b1;
                        state   <= DONE;
                    end
                end
                DIV_RUN: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        opa <= quo_nx;
                        rem <= rem_nx;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            hi_out  <= rem_fix;
                            lo_out  <= quo_fix;
                            done    <= 1'b1;
                            hilo_we <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  EX-stage request valid; held high by the pipeline while stalled.
REQ-004 SHALL have port: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: src1  input  32  multiplicand / dividend.
REQ-006 SHALL have port: src2  input  32  multiplier / divisor.
REQ-007 SHALL have port: annul  input  1  cancel in-flight operation (flush).
REQ-008 SHALL have port: stall_out  output  1  pipeline stall request.
REQ-009 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: hilo_we  output  1  HI/LO write enable, asserted together with done.
REQ-012 SHALL have port: hi_out  output  32  HI result (product high word / remainder).
REQ-013 SHALL have port: lo_out  output  32  LO result (product low word / quotient).

Function
REQ-014 SHALL implement the states IDLE, MUL, DIV_RUN and DONE.
REQ-015 IDLE, start=1, annul=0: SHALL latch op; MULT/MULTU -> MUL; DIV/DIVU with src2!=0 -> DIV_RUN; DIV/DIVU with src2==0 -> DONE.
REQ-016 Operand prep at acceptance: signed ops (MULT, DIV) SHALL store |src1| and |src2| (two's-complement negate when bit31=1) plus the sign bits; unsigned ops SHALL store the raw operands.
REQ-017 MUL SHALL register the 64-bit magnitude product, then -> DONE; the product SHALL be negated when signed and the operand signs differ.
REQ-018 DIV_RUN SHALL perform a 32-iteration restoring shift-subtract, one quotient bit per cycle MSB-first, 5-bit counter 0..31; counter==31 -> DONE.
REQ-019 Signed divide result: quotient SHALL be negated if the operand signs differ; remainder SHALL take the sign of the dividend.
REQ-020 Divide by zero: DONE SHALL present hi_out=0, lo_out=0.
REQ-021 DONE SHALL assert done=1 and hilo_we=1 for exactly one cycle with valid hi_out/lo_out, then -> IDLE unconditionally; start during DONE SHALL be ignored.
REQ-022 Latency, start accepted in cycle 0: MUL/MULTU done in cycle 2; DIV/DIVU done in cycle 33; divide-by-zero done in cycle 1.
REQ-023 stall_out SHALL be combinational: 1 when (IDLE & start & !annul) or state in {MUL, DIV_RUN}; 0 in DONE and otherwise.
REQ-024 annul=1 in MUL or DIV_RUN SHALL force -> IDLE next cycle with no done/hilo_we pulse; annul=1 in IDLE SHALL block acceptance; annul in DONE SHALL NOT suppress that cycle's write.
REQ-025 Operand changes on src1/src2/op after acceptance SHALL NOT affect the in-flight result.
REQ-026 hi_out/lo_out SHALL hold their last DONE value until the next DONE.

Reset
REQ-027 rstn=0 SHALL immediately force state IDLE, counter 0, all stored operands 0, hi_out=lo_out=0, done=hilo_we=busy=0; stall_out SHALL then follow REQ-023 from start/annul.
REQ-028 Reset asserted mid-operation SHALL abandon it with no hilo_we pulse; after release the block SHALL accept a new start on the first clock.

Verification
REQ-029 DIVU src1=100 src2=7 -> stall_out high cycles 0..32, cycle 33 done=1 hilo_we=1 lo_out=14 hi_out=2, stall_out=0.
REQ-030 DIV src1=0xFFFFFFF9 (-7) src2=2 -> cycle 33 lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
REQ-031 MULT 0xFFFFFFFF x 2 -> cycle 2 hi_out=0xFFFFFFFF lo_out=0xFFFFFFFE; MULTU same operands -> hi_out=0x00000001 lo_out=0xFFFFFFFE.
REQ-032 DIV src2=0 -> cycle 1 done=1 hilo_we=1 hi_out=0 lo_out=0; busy=0 in cycle 2.
REQ-033 DIVU 100/7 with annul=1 in cycle 10 -> IDLE in cycle 11, no done/hilo_we pulse, hi_out/lo_out unchanged; a new MULTU 3x5 then yields lo_out=15 at its cycle 2.
REQ-034 rstn pulsed low in cycle 20 of a DIV -> busy=0 and outputs 0 immediately, no hilo_we pulse; a DIVU 9/3 started after release yields lo_out=3 hi_out=0.
